// File: rtl/bram_sorter.sv
// In-place bubble sorter driving a single-port, one-cycle-latency BRAM; early exit on a swap-free pass.
// Optional macro SORT_SIGNED_EN selects a two's-complement compare instead of unsigned.
module bram_sorter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN        = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycles,
    output logic [31:0]           swaps
);

    typedef enum logic [2:0] {IDLE, RDA, RDB, CMP, WRA, WRB, NEXT} state_t;

    localparam bit          SHORT    = (LEN < 2);
    localparam int unsigned LIM_INIT = SHORT ? 0 : LEN - 1;
    localparam logic [ADDR_WIDTH:0] LIM_RST = (ADDR_WIDTH+1)'(LIM_INIT);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   i;
    logic [ADDR_WIDTH:0]     lim;
    logic [ADDR_WIDTH:0]     i_inc;
    logic [DATA_WIDTH-1:0]   a, b;
    logic                    swapped;
    logic                    greater;
    logic                    last_pair;

    assign i_inc     = {1'b0, i} + ONE;
    assign last_pair = (i_inc == lim);
    assign busy      = (state != IDLE);

    // The decision in CMP uses the word arriving from the BRAM this cycle; b only latches it.
`ifdef SORT_SIGNED_EN
    assign greater = ($signed(a) > $signed(mem_dout));
`else
    assign greater = (a > mem_dout);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        case (state)
            IDLE: if (start && !SHORT) state_nx = RDA;
            RDA: begin
                mem_addr = i;
                state_nx = RDB;
            end
            RDB: begin
                mem_addr = i_inc[ADDR_WIDTH-1:0];
                state_nx = CMP;
            end
            CMP: state_nx = greater ? WRA : NEXT;
            WRA: begin
                mem_addr = i;
                mem_din  = b;
                mem_we   = 1'b1;
                state_nx = WRB;
            end
            WRB: begin
                mem_addr = i_inc[ADDR_WIDTH-1:0];
                mem_din  = a;
                mem_we   = 1'b1;
                state_nx = NEXT;
            end
            NEXT: begin
                if (last_pair && (!swapped || lim == ONE)) state_nx = IDLE;
                else                                      state_nx = RDA;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i       <= '0;
            lim     <= '0;
            a       <= '0;
            b       <= '0;
            swapped <= 1'b0;
            done    <= 1'b0;
            cycles  <= '0;
            swaps   <= '0;
        end else begin
            if (state != IDLE && cycles != '1) cycles <= cycles + 32'd1;
            case (state)
                IDLE: if (start) begin
                    done    <= SHORT;
                    cycles  <= '0;
                    swaps   <= '0;
                    i       <= '0;
                    lim     <= LIM_RST;
                    swapped <= 1'b0;
                end
                RDB: a <= mem_dout;
                CMP: b <= mem_dout;
                WRB: begin
                    swapped <= 1'b1;
                    if (swaps != '1) swaps <= swaps + 32'd1;
                end
                NEXT: begin
                    if (!last_pair) begin
                        i <= i_inc[ADDR_WIDTH-1:0];
                    end else if (!swapped || lim == ONE) begin
                        done <= 1'b1;
                    end else begin
                        lim     <= lim - ONE;
                        i       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
